bus_arb: RTL and testbench
==========================

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter N_MST, default 2, meaning number of bus masters (legal range 2..8).
REQ-002 SHALL have parameter AW, default 16, meaning address width.
REQ-003 SHALL have parameter DW, default 8, meaning data width.
REQ-004 SHALL have parameter MODE, default 0, meaning arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL have port clk, input, 1, system clock; one clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port m_req, input, N_MST, per-master request; the master holds it until granted.
REQ-008 SHALL have port m_r_nw, input, N_MST, per-master read (1) or write (0).
REQ-009 SHALL have port m_a, input, N_MST*AW, per-master address, packed with master 0 in the LSBs.
REQ-010 SHALL have port m_wdata, input, N_MST*DW, per-master write data, packed.
REQ-011 SHALL have port m_lock, input, N_MST, per-master exclusive-ownership request (debug break).
REQ-012 SHALL have port m_gnt, output, N_MST, one-cycle accept pulse.
REQ-013 SHALL have port m_rvalid, output, N_MST, one-cycle read-data-valid pulse.
REQ-014 SHALL have port m_rdata, output, DW, read data shared by all masters; qualified by m_rvalid.
REQ-015 SHALL have port mem_a, output, AW, memory address.
REQ-016 SHALL have port mem_wr, output, 1, memory write strobe.
REQ-017 SHALL have port mem_din, output, DW, memory write data.
REQ-018 SHALL have port mem_dout, input, DW, memory read data, valid one cycle after the address.
REQ-019 SHALL have port owner, output, clog2(N_MST), index of the current or last granted master.
REQ-020 SHALL have port locked, output, 1, high while lock ownership is held.

Function
REQ-021 SHALL implement states IDLE, XFER, RDATA.
REQ-022 In IDLE with any eligible request, SHALL select winner w, latch m_a/m_r_nw/m_wdata of w, and go to XFER.
REQ-023 In IDLE with no eligible request, SHALL remain in IDLE with mem_wr=0.
REQ-024 In XFER, SHALL drive the latched request onto mem_a/mem_din for exactly one cycle, set mem_wr=~r_nw, and pulse m_gnt[w].
REQ-025 From XFER, SHALL go to IDLE on a write and to RDATA on a read.
REQ-026 In RDATA, SHALL register m_rdata=mem_dout, pulse m_rvalid[w], and go to IDLE.
REQ-027 Latency: req at cycle 0 -> m_gnt at cycle 1 -> m_rvalid at cycle 2; a write occupies 2 cycles and a read 3.
REQ-028 MODE 0: lowest index SHALL win.
REQ-029 MODE 1: search SHALL start at (last winner+1) mod N_MST and wrap around.
REQ-030 Lock: if m_lock[w] is high when w is granted, locked SHALL set and only w SHALL be eligible until m_lock[w] falls.
REQ-031 The lock SHALL release at the next IDLE evaluation after m_lock[w] falls; the round-robin pointer SHALL be unaffected by lock cycles except advancing past w.
REQ-032 Dropping m_req during XFER/RDATA SHALL NOT abort the transfer, since it is latched.
REQ-033 Changes to m_req of non-winners during a transfer SHALL be ignored until IDLE.
REQ-034 m_gnt and m_rvalid SHALL be one-hot or zero.
REQ-035 mem_wr SHALL never be high outside XFER.

Reset
REQ-036 Asserting rst at any time, including mid-transfer, SHALL immediately force IDLE; m_gnt, m_rvalid, mem_wr, locked, owner, m_rdata, mem_a, mem_din, and the round-robin pointer SHALL all be 0.
REQ-037 An interrupted transfer SHALL NOT be replayed after reset.
REQ-038 The first arbitration SHALL occur in the first IDLE cycle after rst deasserts.

Structure
REQ-039 Package bus_arb_pkg SHALL hold the state enum and the MODE_FIXED/MODE_RR constants.
REQ-040 Winner selection SHALL be one combinational sub-module, bus_arb_pick (request vector, start index, mode -> winner, valid).
REQ-041 Data path registers and the FSM SHALL live in bus_arb.

Verification
REQ-042 N_MST=2, MODE=0; both masters request reads of 0x0010 and 0x0020 -> master 0 granted at cycle 1, m_rvalid[0] at cycle 2 with mem[0x0010]; then master 1.
REQ-043 N_MST=4, MODE=1; all four request continuously -> grant order 0,1,2,3,0; each write spaced 2 cycles.
REQ-044 Master 1 write 0xA5 to 0x0300, then read 0x0300 -> mem_wr is high for exactly one cycle and m_rdata=0xA5.
REQ-045 Master 1 holds m_lock while master 0 requests -> master 0 receives no m_gnt; after m_lock falls, master 0 is granted within 2 cycles.
REQ-046 rst pulsed during RDATA -> no m_rvalid, all outputs 0, and the next arbitration restarts with master 0 priority.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding and
// arbitration policy selectors.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection: fixed priority from index 0, or a circular
// search beginning at a start index.
module bus_arb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    input  logic                 mode,
    output logic [$clog2(N)-1:0] winner,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    int            idx;
    logic [IW-1:0] sel;

    // NOTE: every combinational output gets a default before the search loop;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < N; i++) begin
            idx = (mode ? int'(start) : 0) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!valid && req[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// Multi-master to single-memory arbiter: picks one master per transfer,
// latches its request, and sequences a one-cycle write or a two-cycle read.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int N_MST = 2,
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int MODE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MST-1:0]         m_req,
    input  logic [N_MST-1:0]         m_r_nw,
    input  logic [N_MST*AW-1:0]      m_a,
    input  logic [N_MST*DW-1:0]      m_wdata,
    input  logic [N_MST-1:0]         m_lock,
    output logic [N_MST-1:0]         m_gnt,
    output logic [N_MST-1:0]         m_rvalid,
    output logic [DW-1:0]            m_rdata,
    output logic [AW-1:0]            mem_a,
    output logic                     mem_wr,
    output logic [DW-1:0]            mem_din,
    input  logic [DW-1:0]            mem_dout,
    output logic [$clog2(N_MST)-1:0] owner,
    output logic                     locked
);

    localparam int IW = $clog2(N_MST);
    localparam logic [N_MST-1:0] ONE = N_MST'(1);

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rnw_q;
    logic [DW-1:0] rdata_q;

    logic [N_MST-1:0] eligible;
    logic [IW-1:0]    pick_start;
    logic [IW-1:0]    pick_w;
    logic             pick_valid;
    logic [IW-1:0]    rr_next;

    // While the lock owner keeps m_lock high, nobody else may compete.
    always_comb begin
        eligible = m_req;
        if (locked && m_lock[owner]) begin
            eligible = m_req & (ONE << owner);
        end
    end

    assign pick_start = (MODE == MODE_RR) ? rr_ptr : '0;
    assign rr_next    = (pick_w == IW'(N_MST - 1)) ? '0 : pick_w + 1'b1;

    bus_arb_pick #(
        .N (N_MST)
    ) u_pick (
        .req    (eligible),
        .start  (pick_start),
        .mode   (MODE == MODE_RR),
        .winner (pick_w),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = XFER;
            XFER:    state_d = rnw_q ? RDATA : IDLE;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner   <= '0;
            locked  <= 1'b0;
            rr_ptr  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rnw_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (pick_valid) begin
                    owner   <= pick_w;
                    rr_ptr  <= rr_next;
                    addr_q  <= m_a[int'(pick_w)*AW +: AW];
                    wdata_q <= m_wdata[int'(pick_w)*DW +: DW];
                    rnw_q   <= m_r_nw[pick_w];
                    locked  <= m_lock[pick_w];
                end else if (locked && !m_lock[owner]) begin
                    locked <= 1'b0;
                end
            end
            if (state_q == RDATA) begin
                rdata_q <= mem_dout;
            end
        end
    end

    // Read data passes through while valid, then the captured copy is held.
    assign m_gnt    = (state_q == XFER)  ? (ONE << owner) : '0;
    assign m_rvalid = (state_q == RDATA) ? (ONE << owner) : '0;
    assign m_rdata  = (state_q == RDATA) ? mem_dout : rdata_q;
    assign mem_wr   = (state_q == XFER) && !rnw_q;
    assign mem_a    = (state_q == XFER) ? addr_q  : '0;
    assign mem_din  = (state_q == XFER) ? wdata_q : '0;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench: a 2-master fixed-priority arbiter and a 4-master round-robin
// arbiter, each driving a small synchronous memory model.
module tb_bus_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Fixed-priority instance, two masters
    logic [1:0]  f_req  = '0;
    logic [1:0]  f_rnw  = '0;
    logic [31:0] f_a    = '0;
    logic [15:0] f_wd   = '0;
    logic [1:0]  f_lock = '0;
    logic [1:0]  f_gnt, f_rvalid;
    logic [7:0]  f_rdata, f_mem_din;
    logic [7:0]  f_mem_dout = '0;
    logic [15:0] f_mem_a;
    logic        f_mem_wr, f_locked;
    logic [0:0]  f_owner;

    // Round-robin instance, four masters
    logic [3:0]  r_req  = '0;
    logic [3:0]  r_rnw  = '0;
    logic [63:0] r_a    = '0;
    logic [31:0] r_wd   = '0;
    logic [3:0]  r_lock = '0;
    logic [3:0]  r_gnt, r_rvalid;
    logic [7:0]  r_rdata, r_mem_din;
    logic [7:0]  r_mem_dout = '0;
    logic [15:0] r_mem_a;
    logic        r_mem_wr, r_locked;
    logic [1:0]  r_owner;

    bus_arb #(.N_MST(2), .AW(16), .DW(8), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .m_req(f_req), .m_r_nw(f_rnw), .m_a(f_a),
        .m_wdata(f_wd), .m_lock(f_lock), .m_gnt(f_gnt), .m_rvalid(f_rvalid),
        .m_rdata(f_rdata), .mem_a(f_mem_a), .mem_wr(f_mem_wr),
        .mem_din(f_mem_din), .mem_dout(f_mem_dout), .owner(f_owner),
        .locked(f_locked)
    );

    bus_arb #(.N_MST(4), .AW(16), .DW(8), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .m_req(r_req), .m_r_nw(r_rnw), .m_a(r_a),
        .m_wdata(r_wd), .m_lock(r_lock), .m_gnt(r_gnt), .m_rvalid(r_rvalid),
        .m_rdata(r_rdata), .mem_a(r_mem_a), .mem_wr(r_mem_wr),
        .mem_din(r_mem_din), .mem_dout(r_mem_dout), .owner(r_owner),
        .locked(r_locked)
    );

    // Synchronous memory: contents preset to (addr ^ 0x5A)
    logic [7:0] fmem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) fmem[i] = 8'(i) ^ 8'h5A;
    end
    always @(posedge clk) begin
        if (f_mem_wr) fmem[f_mem_a[11:0]] <= f_mem_din;
        f_mem_dout <= fmem[f_mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        bit granted;

        // Reset state
        step();
        step();
        check("rst_gnt",    32'(f_gnt),     32'h0);
        check("rst_rvalid", 32'(f_rvalid),  32'h0);
        check("rst_mem_wr", 32'(f_mem_wr),  32'h0);
        check("rst_locked", 32'(f_locked),  32'h0);
        check("rst_owner",  32'(f_owner),   32'h0);
        check("rst_rdata",  32'(f_rdata),   32'h0);
        check("rst_mem_a",  32'(f_mem_a),   32'h0);
        check("rst_rr_gnt", 32'(r_gnt),     32'h0);
        rst = 1'b1;

        // Both masters read: master 0 first, then master 1
        step();
        f_req = 2'b11;
        f_rnw = 2'b11;
        f_a   = {16'h0020, 16'h0010};
        step();
        check("rd0_gnt",    32'(f_gnt),    32'h1);
        check("rd0_mem_a",  32'(f_mem_a),  32'h0010);
        check("rd0_mem_wr", 32'(f_mem_wr), 32'h0);
        check("rd0_owner",  32'(f_owner),  32'h0);
        f_req = 2'b10;
        step();
        check("rd0_rvalid", 32'(f_rvalid), 32'h1);
        check("rd0_rdata",  32'(f_rdata),  32'h4A);
        check("rd0_gnt_off", 32'(f_gnt),   32'h0);
        step();
        check("rd_idle_gnt", 32'(f_gnt),   32'h0);
        step();
        check("rd1_gnt",    32'(f_gnt),    32'h2);
        check("rd1_mem_a",  32'(f_mem_a),  32'h0020);
        f_req = 2'b00;
        step();
        check("rd1_rvalid", 32'(f_rvalid), 32'h2);
        check("rd1_rdata",  32'(f_rdata),  32'h7A);

        // Master 1 writes 0xA5 to 0x0300, then reads it back
        f_req = 2'b10;
        f_rnw = 2'b00;
        f_a   = {16'h0300, 16'h0000};
        f_wd  = {8'hA5, 8'h00};
        step();
        check("wr_idle_gnt", 32'(f_gnt), 32'h0);
        step();
        check("wr_mem_wr",  32'(f_mem_wr),  32'h1);
        check("wr_gnt",     32'(f_gnt),     32'h2);
        check("wr_mem_a",   32'(f_mem_a),   32'h0300);
        check("wr_mem_din", 32'(f_mem_din), 32'hA5);
        f_req = 2'b00;
        step();
        check("wr_mem_wr_once", 32'(f_mem_wr), 32'h0);
        check("wr_gnt_off",     32'(f_gnt),    32'h0);
        f_req = 2'b10;
        f_rnw = 2'b10;
        step();
        check("rb_mem_wr", 32'(f_mem_wr), 32'h0);
        check("rb_gnt",    32'(f_gnt),    32'h2);
        f_req = 2'b00;
        step();
        check("rb_rvalid", 32'(f_rvalid), 32'h2);
        check("rb_rdata",  32'(f_rdata),  32'hA5);
        step();
        check("rb_rdata_hold", 32'(f_rdata),  32'hA5);
        check("rb_rvalid_off", 32'(f_rvalid), 32'h0);

        // Master 1 takes the lock; master 0 must be starved until it drops
        f_req  = 2'b10;
        f_lock = 2'b10;
        f_rnw  = 2'b00;
        step();
        check("lk_gnt",    32'(f_gnt),    32'h2);
        check("lk_locked", 32'(f_locked), 32'h1);
        check("lk_owner",  32'(f_owner),  32'h1);
        f_req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            check("lk_starve_gnt0", 32'(f_gnt[0]), 32'h0);
            check("lk_held",        32'(f_locked), 32'h1);
        end
        f_lock  = 2'b00;
        granted = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (f_gnt == 2'b01) begin
                granted = 1'b1;
                break;
            end
        end
        check("lk_release_gnt0", 32'(granted), 32'h1);
        check("lk_released",     32'(f_locked), 32'h0);
        f_req = 2'b00;
        step();

        // Round-robin with all four masters writing continuously
        r_req = 4'b1111;
        r_rnw = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_gnt",    32'(r_gnt),    32'(4'b0001 << (i % 4)));
            check("rr_mem_wr", 32'(r_mem_wr), 32'h1);
            if (i == 4) r_req = 4'b0000;
            step();
            check("rr_gap_gnt", 32'(r_gnt), 32'h0);
        end

        // Reset asserted in the middle of a read's RDATA cycle
        f_req = 2'b10;
        f_rnw = 2'b10;
        f_a   = {16'h0010, 16'h0000};
        step();
        check("mr_gnt", 32'(f_gnt), 32'h2);
        f_req = 2'b00;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mr_rvalid",  32'(f_rvalid),  32'h0);
        check("mr_gnt_off", 32'(f_gnt),     32'h0);
        check("mr_mem_wr",  32'(f_mem_wr),  32'h0);
        check("mr_locked",  32'(f_locked),  32'h0);
        check("mr_owner",   32'(f_owner),   32'h0);
        check("mr_rdata",   32'(f_rdata),   32'h0);
        check("mr_mem_a",   32'(f_mem_a),   32'h0);
        check("mr_mem_din", 32'(f_mem_din), 32'h0);
        check("mr_rr_owner", 32'(r_owner),  32'h0);
        step();
        rst = 1'b1;
        step();
        check("mr_no_replay_rvalid", 32'(f_rvalid), 32'h0);
        check("mr_no_replay_gnt",    32'(f_gnt),    32'h0);
        f_req = 2'b11;
        f_rnw = 2'b00;
        r_req = 4'b0011;
        step();
        check("mr_fix_first",  32'(f_gnt), 32'h1);
        check("mr_rr_restart", 32'(r_gnt), 32'h1);
        f_req = 2'b00;
        r_req = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
